// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int FETCH_ADDR_W = 32;
  localparam int FETCH_DATA_W = 32;

  localparam int unsigned PC_STEP = 4;
  localparam logic [FETCH_ADDR_W-1:0] RESET_PC_DEF = '0;

  typedef enum logic [1:0] {
    ISSUE   = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small power-of-two FIFO with synchronous flush; head is read combinationally from storage.
// Latency: a push is visible at the head one edge later.
// Backpressure: push is accepted when not full or when popping in the same cycle; flush wins over both.
module fetch_queue #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_dat,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: entries are only observed through count.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: req/ack word reads from RESET_PC, queued to decode, redirect flushes; FETCH_ALIGN_CHECK_EN adds misaligned-redirect halt.
// Latency: first request 1 edge after reset release, data at decode 1 edge after ack, 1 instr/cycle with 0-wait memory.
// Backpressure: no request is issued unless the queue has room counting same-cycle push and pop.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W      = FETCH_ADDR_W,
  parameter int                DATA_W      = FETCH_DATA_W,
  parameter int                QUEUE_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              misalign_err
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc, pc_d, addr_d, redir_pc;
  logic              req_d;
  logic              push, pop, flush, halt;
  logic              q_full, q_empty;
  logic [CNT_W-1:0]  q_count;
  fetch_entry_t      push_ent, head_ent;

  assign redir_pc = redirect_pc & ~ADDR_W'(3);
  assign pop      = instr_valid && instr_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ISSUE;
      fetch_pc  <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      state_q   <= state_d;
      fetch_pc  <= pc_d;
      imem_req  <= req_d;
      imem_addr <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = fetch_pc;
    push    = 1'b0;
    flush   = 1'b0;
    case (state_q)
      ISSUE: begin
        if (redirect_valid) begin
          flush = 1'b1;
          pc_d  = redir_pc;
        end else if (!q_full && !halt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          flush   = 1'b1;
          pc_d    = redir_pc;
          state_d = imem_ack ? ISSUE : DISCARD;
        end else if (imem_ack) begin
          push = 1'b1;
          pc_d = fetch_pc + ADDR_W'(PC_STEP);
          // Room after this push: either a pop frees a slot or one was already spare.
          state_d = (pop || (q_count < CNT_W'(QUEUE_DEPTH - 1))) ? WAIT : ISSUE;
        end
      end
      DISCARD: begin
        if (redirect_valid) begin
          flush = 1'b1;
          pc_d  = redir_pc;
        end
        if (imem_ack) state_d = ISSUE;
      end
      default: state_d = ISSUE;
    endcase
  end

  // Address only advances when a fresh request is (re)issued; DISCARD holds the abandoned one.
  always_comb begin
    req_d  = (state_d != ISSUE);
    addr_d = (state_d == WAIT) ? pc_d : imem_addr;
  end

  assign push_ent.pc    = FETCH_ADDR_W'(fetch_pc);
  assign push_ent.instr = FETCH_DATA_W'(imem_rdata);

  fetch_queue #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat (push_ent),
    .pop      (pop),
    .flush    (flush),
    .head_dat (head_ent),
    .count    (q_count),
    .full     (q_full),
    .empty    (q_empty)
  );

  assign instr_valid = !q_empty;
  assign instr_data  = q_empty ? '0 : DATA_W'(head_ent.instr);
  assign instr_pc    = q_empty ? '0 : ADDR_W'(head_ent.pc);

`ifdef FETCH_ALIGN_CHECK_EN
  logic err_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                           err_q <= 1'b0;
    else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) err_q <= 1'b1;
  end
  assign misalign_err = err_q;
`else
  assign misalign_err = 1'b0;
`endif

  assign halt = misalign_err;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch reader that sits between the program counter and decode.
- Walks the instruction address stream from a reset vector and issues word reads to instruction memory over a req/ack handshake.
- Buffers returned words with their PC in a small queue and delivers them to decode with valid/ready.
- Branch/jump logic redirects it through a redirect port, which flushes buffered and in-flight fetches.

Parameters:
ADDR_W, 32, instruction address width
DATA_W, 32, instruction word width
QUEUE_DEPTH, 2, instruction queue entries (power of two, >=2)
RESET_PC, 32'h0, first fetch address after reset

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous active-low reset (0 = reset asserted)
redirect_valid  in  1  one-cycle pulse: restart fetch at redirect_pc
redirect_pc  in  ADDR_W  redirect target
imem_req  out  1  read request, held until imem_ack
imem_addr  out  ADDR_W  word address of request, stable while imem_req=1
imem_ack  in  1  one-cycle pulse: imem_rdata valid this cycle
imem_rdata  in  DATA_W  returned instruction word
instr_valid  out  1  queue head valid
instr_ready  in  1  decode accepts head this cycle
instr_data  out  DATA_W  head instruction
instr_pc  out  ADDR_W  head instruction address
misalign_err  out  1  sticky misaligned-redirect flag (see Optional Feature)

Behaviour:
- Reset (reset=0, async) forces:
  - imem_req=0, imem_addr=RESET_PC, fetch_pc=RESET_PC
  - queue empty, instr_valid=0, instr_data=0, instr_pc=0
  - misalign_err=0, state=ISSUE
- Reset asserted mid-transaction drops imem_req immediately; memory must tolerate an abandoned request.
- Registered outputs only; no combinational path from any input to imem_req or instr_valid.
- State machine:
  - ISSUE: imem_req=0. If space (count < QUEUE_DEPTH), assert imem_req next edge with imem_addr=fetch_pc and go to WAIT.
  - WAIT: imem_req=1, ack sampled each edge.
    - On imem_ack: push {fetch_pc, imem_rdata} and set fetch_pc += 4 (mod 2^ADDR_W, wraps FFFF_FFFC -> 0).
    - Then, if space remains counting the push and any same-cycle pop, stay in WAIT with imem_req=1 and the new address (back-to-back, 1 instr/cycle with 0-wait memory). Otherwise go to ISSUE with req=0.
  - DISCARD: entered on redirect while in WAIT without ack. imem_req stays 1 and imem_addr is held at the old address. On imem_ack the data is dropped and state goes to ISSUE (fetch_pc already holds redirect target).
- imem_ack is only honoured when imem_req=1; otherwise it is ignored.
- Queue:
  - FIFO; head drives instr_*.
  - Pop when instr_valid & instr_ready.
  - Push and pop in the same cycle are legal when full.
  - instr_valid=0 whenever empty.
- Redirect (highest priority):
  - Next edge: queue flushed, instr_valid=0, fetch_pc=redirect_pc with bits [1:0] forced 0.
  - From ISSUE: go to ISSUE; req rises the following edge.
  - From WAIT without ack: go to DISCARD.
  - From WAIT with simultaneous ack: ack data dropped, go to ISSUE (no DISCARD).
  - A simultaneous pop is ignored (queue flushed anyway).
- Redirect during DISCARD: fetch_pc is updated to the newer target; remain in DISCARD.
- Redirect-to-first-request latency: 2 edges from ISSUE; after DISCARD, ack + 1 edge.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - A redirect with redirect_pc[1:0]!=0 sets misalign_err=1 (sticky until reset).
  - The queue is flushed and the FSM halts in ISSUE: no further requests, even if a later redirect is aligned.
  - Any in-flight request completes through DISCARD first.
- Undefined: misalign_err tied 0; low bits silently cleared.

Decomposition:
- Shared package fetch_pkg holds:
  - state enum {ISSUE, WAIT, DISCARD}
  - PC_STEP=4
  - the queue entry struct {pc, instr}
  - RESET_PC default
- One natural sub-module: fetch_queue (parameterised FIFO with push, pop, flush, count, full, empty), instantiated once for {pc, instr} entries.

Test Plan:
- Reset release, memory acks same cycle as req, instr_ready=1 -> imem_addr 0,4,8,C on consecutive cycles; instr_pc/instr_data stream 1 per cycle starting 1 edge after first ack.
- instr_ready=0, continuous acks -> exactly 2 pushes (QUEUE_DEPTH=2), imem_req drops, instr_pc=0 held; raising ready resumes fetch at 8.
- Memory ack delayed 3 cycles, redirect to 0x100 during wait -> old data dropped, queue empty, next req at 0x100 one edge after ack, first delivered instr_pc=0x100.
- Redirect coincident with ack for addr 0x20 -> 0x20 word never delivered, next req to target with no extra wait.
- Fetch from 0xFFFF_FFFC -> next imem_addr 0x0000_0000.
- With FETCH_ALIGN_CHECK_EN, redirect to 0x102 -> misalign_err=1, no further imem_req; reset (0) clears it and fetch restarts at RESET_PC.
